// File: rtl/cam_capture_pkg.sv
// Shared types for the camera stream capture block: FSM states, the crop
// coordinate type and the frame counter width.
package cam_capture_pkg;

  localparam int FRAME_CNT_W = 16;

  typedef logic [11:0] coord_t;

  typedef enum logic [1:0] {
    WAIT_VS    = 2'd0,
    WAIT_FRAME = 2'd1,
    ACTIVE     = 2'd2,
    DROP       = 2'd3
  } cap_state_e;

endpackage

// File: rtl/cam_capture_fifo.sv
// Single-clock FIFO with registered head-of-queue output and registered
// full/empty flags. rd_data reads as zero whenever the FIFO is empty.
module cam_capture_fifo #(
  parameter int W     = 18,
  parameter int DEPTH = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         wr_en,
  input  logic [W-1:0] wr_data,
  input  logic         rd_en,
  output logic [W-1:0] rd_data,
  output logic         full,
  output logic         empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [W-1:0]  mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr, rd_ptr_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic          do_wr, do_rd;

  // A write into a full FIFO is accepted only when a read frees a slot this cycle.
  assign do_rd     = rd_en && !empty;
  assign do_wr     = wr_en && (!full || do_rd);
  assign rd_ptr_nx = do_rd ? rd_ptr + 1'b1 : rd_ptr;
  assign cnt_nx    = cnt + CW'(do_wr) - CW'(do_rd);

  always_ff @(posedge clk)
    if (do_wr) mem[wr_ptr] <= wr_data;

  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      cnt     <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
      rd_data <= '0;
    end else begin
      if (do_wr) wr_ptr <= wr_ptr + 1'b1;
      rd_ptr <= rd_ptr_nx;
      cnt    <= cnt_nx;
      empty  <= (cnt_nx == '0);
      full   <= (cnt_nx == CW'(DEPTH));
      // Preload the next head; bypass the write when it lands in the head slot.
      if (cnt_nx == '0)                      rd_data <= '0;
      else if (do_wr && wr_ptr == rd_ptr_nx) rd_data <= wr_data;
      else                                   rd_data <= mem[rd_ptr_nx];
    end

endmodule

// File: rtl/cam_stream_capture.sv
// DVP-style camera to AXI4-Stream pixel capture with frame FSM and output FIFO.
// Define CAM_CAPTURE_CROP_EN to add the crop window inputs.
module cam_stream_capture
  import cam_capture_pkg::*;
#(
  parameter int DIN_W         = 8,
  parameter int BYTES_PER_PIX = 2,
  parameter int FIFO_DEPTH    = 8
) (
  input  logic                           pclk,
  input  logic                           reset,
  input  logic [DIN_W-1:0]               vdin,
  input  logic                           vsync,
  input  logic                           href,
`ifdef CAM_CAPTURE_CROP_EN
  input  coord_t                         crop_x0,
  input  coord_t                         crop_x1,
  input  coord_t                         crop_y0,
  input  coord_t                         crop_y1,
`endif
  output logic [DIN_W*BYTES_PER_PIX-1:0] m_tdata,
  output logic                           m_tvalid,
  output logic                           m_tuser,
  output logic                           m_tlast,
  input  logic                           m_tready,
  output logic                           overflow,
  output logic                           err_partial,
  output logic [FRAME_CNT_W-1:0]         frame_cnt,
  input  logic                           clear_err
);
  localparam int PIX_W = DIN_W * BYTES_PER_PIX;
  localparam int PH_W  = (BYTES_PER_PIX > 1) ? $clog2(BYTES_PER_PIX) : 1;

  cap_state_e       state_q, state_d;
  logic             href_q, sof_q, hold_vld_q;
  logic [PH_W-1:0]  phase_q;
  logic [PIX_W-1:0] asm_q, asm_shift, hold_q;
  logic             cap_en, href_fall, pix_done, line_end, in_win;
  logic             push, drop, accept, err_set, fifo_full, fifo_empty;
  logic [PIX_W+1:0] fifo_dout;

  assign cap_en    = (state_q == ACTIVE) && !vsync;
  assign href_fall = cap_en && href_q && !href;
  assign pix_done  = cap_en && href && (phase_q == PH_W'(BYTES_PER_PIX - 1));
  assign asm_shift = (asm_q << DIN_W) | PIX_W'(vdin);
  // End of line (href fall) or end of frame (vsync rise) flushes the held pixel.
  assign line_end  = (state_q == ACTIVE) && (vsync || (href_q && !href));
  assign push      = hold_vld_q && ((pix_done && in_win) || line_end);
  assign drop      = push && fifo_full && !m_tready;
  assign accept    = push && !drop;
  assign err_set   = href_fall && (phase_q != '0);

`ifdef CAM_CAPTURE_CROP_EN
  coord_t x_q, y_q;

  assign in_win = (x_q >= crop_x0) && (x_q <= crop_x1) &&
                  (y_q >= crop_y0) && (y_q <= crop_y1);

  always_ff @(posedge pclk or posedge reset)
    if (reset) begin
      x_q <= '0;
      y_q <= '0;
    end else if (state_q == WAIT_FRAME) begin
      x_q <= '0;
      y_q <= '0;
    end else if (pix_done) begin
      x_q <= x_q + 1'b1;
    end else if (href_fall) begin
      x_q <= '0;
      y_q <= y_q + 1'b1;
    end
`else
  assign in_win = 1'b1;
`endif

  always_ff @(posedge pclk or posedge reset)
    if (reset) state_q <= WAIT_VS;
    else       state_q <= state_d;

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      WAIT_VS:    if (vsync) state_d = WAIT_FRAME;
      WAIT_FRAME: if (!vsync) state_d = ACTIVE;
      ACTIVE: begin
        if (drop)       state_d = DROP;
        else if (vsync) state_d = WAIT_FRAME;
      end
      DROP:       if (vsync) state_d = WAIT_FRAME;
      default:    state_d = WAIT_VS;
    endcase
  end

  always_ff @(posedge pclk or posedge reset)
    if (reset) begin
      href_q      <= 1'b0;
      sof_q       <= 1'b0;
      hold_vld_q  <= 1'b0;
      phase_q     <= '0;
      asm_q       <= '0;
      hold_q      <= '0;
      overflow    <= 1'b0;
      err_partial <= 1'b0;
      frame_cnt   <= '0;
    end else begin
      href_q <= href;
      if (state_q == WAIT_FRAME && !vsync) sof_q <= 1'b1;
      else if (accept)                     sof_q <= 1'b0;

      if (!cap_en) begin
        phase_q    <= '0;
        hold_vld_q <= 1'b0;
      end else if (href) begin
        asm_q <= asm_shift;
        if (pix_done) begin
          phase_q <= '0;
          if (in_win) begin
            hold_q     <= asm_shift;
            hold_vld_q <= 1'b1;
          end
        end else begin
          phase_q <= phase_q + 1'b1;
        end
      end else if (href_q) begin
        phase_q    <= '0;
        hold_vld_q <= 1'b0;
      end

      // Set wins over a simultaneous clear.
      if (drop)           overflow <= 1'b1;
      else if (clear_err) overflow <= 1'b0;
      if (err_set)        err_partial <= 1'b1;
      else if (clear_err) err_partial <= 1'b0;

      if (state_q == ACTIVE && vsync && !drop) frame_cnt <= frame_cnt + 1'b1;
    end

  cam_capture_fifo #(
    .W     (PIX_W + 2),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (pclk),
    .rst     (reset),
    .wr_en   (accept),
    .wr_data ({sof_q, line_end, hold_q}),
    .rd_en   (m_tready),
    .rd_data (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty)
  );

  assign m_tvalid = !fifo_empty;
  assign {m_tuser, m_tlast, m_tdata} = fifo_dout;

endmodule

// File: doc/cam_stream_capture.md
CAM_STREAM_CAPTURE -- requirements
Module: cam_stream_capture

Interface
REQ-001 DIN_W, 8, camera data bus width in bits; SHALL be 8 or 10.
REQ-002 BYTES_PER_PIX, 2, bus beats per pixel (1..4); tdata width = DIN_W*BYTES_PER_PIX.
REQ-003 FIFO_DEPTH, 8, output buffer depth in pixels; power of 2, at least 4.
REQ-004 pclk  in  1  sole clock, camera pixel clock; all logic on rising edge.
REQ-005 reset  in  1  asynchronous, active-high reset.
REQ-006 vdin  in  DIN_W  camera data, sampled when href=1.
REQ-007 vsync  in  1  frame sync; high between frames.
REQ-008 href  in  1  line-valid qualifier.
REQ-009 m_tdata, m_tvalid, m_tuser, m_tlast  out  DIN_W*BYTES_PER_PIX/1/1/1  AXI4-Stream-style pixel, valid, start-of-frame, end-of-line.
REQ-010 m_tready  in  1  downstream ready.
REQ-011 overflow  out  1  sticky; set when a pixel is dropped because the FIFO is full.
REQ-012 err_partial  out  1  sticky; set when href falls with an incomplete pixel.
REQ-013 frame_cnt  out  16  count of completed frames, wraps 0xFFFF->0.
REQ-014 clear_err  in  1  synchronous clear of both sticky flags.

Function
REQ-015 FSM states: WAIT_VS (await vsync high), WAIT_FRAME (await vsync fall), ACTIVE (capture lines), DROP (discard until next vsync rise).
REQ-016 Transitions: WAIT_VS->WAIT_FRAME on vsync=1; WAIT_FRAME->ACTIVE on vsync=0; ACTIVE->WAIT_FRAME on vsync=1, with frame_cnt incrementing; ACTIVE->DROP on overflow; DROP->WAIT_FRAME on vsync=1, without incrementing frame_cnt.
REQ-017 In ACTIVE with href=1, bytes assemble MSB-first; the first beat lands in tdata[top DIN_W bits].
REQ-018 A completed pixel is placed in a one-entry hold register; the previously held pixel is pushed with tlast=0.
REQ-019 On an href falling edge, the held pixel is pushed with tlast=1; line latency is 1 pclk after href falls.
REQ-020 The first pixel pushed after entering ACTIVE carries tuser=1; all other pixels carry tuser=0.
REQ-021 A push occurs when the FIFO is full: the pixel is dropped, overflow is set, and the FSM enters DROP.
REQ-022 The FIFO pops when m_tvalid and m_tready are both 1; push and pop in the same cycle on a full FIFO do not overflow.
REQ-023 m_tvalid is high whenever the FIFO is non-empty; m_tdata, m_tuser and m_tlast are stable while m_tvalid=1 and m_tready=0.
REQ-024 A partial pixel at an href fall is discarded, err_partial is set, and the byte phase resets to 0.
REQ-025 When vsync rises with href=1, the held pixel is pushed with tlast=1.
REQ-026 When clear_err and a new error occur in the same cycle, the flag is set (set wins).

Reset
REQ-027 While reset is asserted, state=WAIT_VS; m_tvalid, m_tuser, m_tlast, overflow and err_partial are 0; m_tdata=0; frame_cnt=0; the FIFO is empty; the hold register is invalid.
REQ-028 A reset asserted mid-frame aborts capture immediately; capture resumes only after a full vsync high-to-low sequence.

Configuration
REQ-029 Macro CAM_CAPTURE_CROP_EN adds inputs crop_x0, crop_x1, crop_y0 and crop_y1 (12 bits each, inclusive pixel/line indices).
REQ-030 With CAM_CAPTURE_CROP_EN defined, only pixels inside the window are pushed; tlast marks the last pushed pixel of each line; tuser marks the first pushed pixel of the frame.
REQ-031 With CAM_CAPTURE_CROP_EN defined, lines outside crop_y0..crop_y1 produce no output.
REQ-032 Without CAM_CAPTURE_CROP_EN, the crop ports are absent and every pixel passes.

Structure
REQ-033 Package cam_capture_pkg SHALL hold the FSM state enum, the 12-bit coordinate type, and the frame_cnt width constant.
REQ-034 Sub-module cam_capture_fifo SHALL be a single-clock FIFO, FIFO_DEPTH deep, with registered outputs and full/empty flags.

Verification
REQ-035 2 lines x 4 pixels, BYTES_PER_PIX=2, bytes 0x01..0x10 -> tdata 0x0102, 0x0304, ...; tuser on 0x0102 only; tlast on the 4th and 8th pixels.
REQ-036 m_tready=0 for a 12-pixel line with FIFO_DEPTH=8 -> 8 pixels held, overflow=1, state DROP, frame_cnt unchanged after vsync.
REQ-037 href falls after 3 bytes -> one pixel output, err_partial=1; clear_err -> err_partial=0.
REQ-038 Reset asserted mid-line -> all outputs 0 within the same cycle; the next frame starts with tuser=1.
REQ-039 With CAM_CAPTURE_CROP_EN defined and window x 1..2, y 1..1 on a 4x3 frame -> exactly 2 pixels output, first with tuser=1, second with tlast=1.
REQ-040 Run 3 complete frames -> frame_cnt=3; preload frame_cnt=0xFFFF and complete one frame -> frame_cnt=0.
